// File: rtl/ldpc_cnu_minsum.sv
// ---------------------------------------------------------------------------
// ldpc_cnu_minsum
// Serial min-sum check-node unit for the LDPC decoder datapath.
//
// A node is processed in two phases:
//   COLLECT : one variable-to-check LLR is accepted per beat. The unit tracks
//             the two smallest magnitudes, the position of the smallest, the
//             XOR of all signs, and every individual sign.
//   EMIT    : one extrinsic check-to-variable LLR is produced per beat, in the
//             same order as the inputs. Beat k excludes its own contribution:
//             its magnitude is min2 if k held min1, otherwise min1. Its sign is
//             the total parity with sign[k] removed.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high. A producer holding valid keeps its data stable until
// the transfer. The unit is single-buffered: o_in_ready is low during EMIT.
//
// Optional feature macro: LDPC_CNU_OFFSET_EN
//   Defined   -> offset min-sum. Each output magnitude is reduced by OFFSET,
//                floored at 0, before the sign is applied. Latency is unchanged.
//   Undefined -> plain min-sum; OFFSET has no effect.
//
// Ports
//   i_clock      clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_degree     check degree, sampled on the first input beat of a node
//                and clamped to [2, MAX_DEGREE]
//   i_in_data    input LLR (signed two's complement)
//   i_in_valid   input beat valid
//   o_in_ready   unit can accept an input beat (registered)
//   o_out_data   extrinsic LLR (signed, registered)
//   o_out_valid  output beat valid (registered)
//   o_out_last   final output beat of the node (registered)
//   i_out_ready  downstream accepts the output beat
//   o_dbg_state  current phase: 0 = COLLECT, 1 = EMIT
// ---------------------------------------------------------------------------
module ldpc_cnu_minsum #(
  parameter int WIDTH      = 16,
  parameter int MAX_DEGREE = 32,
  parameter int OFFSET     = 1
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [$clog2(MAX_DEGREE+1)-1:0]     i_degree,
  input  logic [WIDTH-1:0]                    i_in_data,
  input  logic                                i_in_valid,
  output logic                                o_in_ready,
  output logic [WIDTH-1:0]                    o_out_data,
  output logic                                o_out_valid,
  output logic                                o_out_last,
  input  logic                                i_out_ready,
  output logic                                o_dbg_state
);

  localparam int DW = $clog2(MAX_DEGREE + 1);              // degree width
  localparam int IW = (MAX_DEGREE > 1) ? $clog2(MAX_DEGREE) : 1; // beat index width
  localparam int MW = WIDTH - 1;                            // magnitude width

  localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};
  localparam logic [MW-1:0] OFF_CFG = MW'(OFFSET);

`ifdef LDPC_CNU_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // |x| with the most negative code saturated to the largest positive value,
  // so every magnitude fits in WIDTH-1 bits and later negation is safe.
  function automatic logic [MW-1:0] abs_sat(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] neg;
    neg = -x;
    if (!x[WIDTH-1]) begin
      abs_sat = x[MW-1:0];
    end else if (x[MW-1:0] == '0) begin
      abs_sat = MAG_MAX;
    end else begin
      abs_sat = neg[MW-1:0];
    end
  endfunction

  // Final output value: optional offset on the magnitude, then the sign.
  // A zero magnitude yields 0 whatever the sign, since -0 == 0.
  // With the offset disabled OFF_EN is a constant and the subtractor folds away.
  function automatic logic [WIDTH-1:0] emit_value(input logic [MW-1:0] m_in,
                                                  input logic          s);
    logic [MW-1:0]    m;
    logic [WIDTH-1:0] ext;
    if (!OFF_EN) begin
      m = m_in;
    end else if (m_in > OFF_CFG) begin
      m = m_in - OFF_CFG;
    end else begin
      m = '0;
    end
    ext        = {1'b0, m};
    emit_value = s ? -ext : ext;
  endfunction

  function automatic logic [DW-1:0] clamp_deg(input logic [DW-1:0] d);
    if (d < DW'(2)) begin
      clamp_deg = DW'(2);
    end else if (d > DW'(MAX_DEGREE)) begin
      clamp_deg = DW'(MAX_DEGREE);
    end else begin
      clamp_deg = d;
    end
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [IW-1:0]         cnt_q,       cnt_d;       // input index / output index
  logic [DW-1:0]         deg_q,       deg_d;
  logic [MW-1:0]         min1_q,      min1_d;
  logic [MW-1:0]         min2_q,      min2_d;
  logic [IW-1:0]         idx_q,       idx_d;       // position of min1
  logic                  parity_q,    parity_d;
  logic [MAX_DEGREE-1:0] sign_q,      sign_d;
  logic                  in_ready_q,  in_ready_d;
  logic [WIDTH-1:0]      out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q,  out_last_d;

  logic          accept;
  logic          out_fire;
  logic [DW-1:0] deg_cur;
  logic [MW-1:0] mag;
  logic [IW-1:0] next_k;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    deg_d       = deg_q;
    min1_d      = min1_q;
    min2_d      = min2_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    accept   = i_in_valid & in_ready_q;
    out_fire = out_valid_q & i_out_ready;
    // The degree is only taken from the port on the first beat of a node;
    // the clamped value is needed on that same beat for the end-of-node test.
    deg_cur  = (cnt_q == '0) ? clamp_deg(i_degree) : deg_q;
    mag      = abs_sat(i_in_data);
    next_k   = cnt_q + IW'(1);

    unique case (state_q)
      S_COLLECT: begin
        if (accept) begin
          deg_d         = deg_cur;
          sign_d[cnt_q] = i_in_data[WIDTH-1];
          parity_d      = parity_q ^ i_in_data[WIDTH-1];
          // Strict compares: on a tie the earlier beat keeps min1.
          if (mag < min1_q) begin
            min2_d = min1_q;
            min1_d = mag;
            idx_d  = cnt_q;
          end else if (mag < min2_q) begin
            min2_d = mag;
          end

          if (DW'(cnt_q) == DW'(deg_cur - DW'(1))) begin
            // Last input: build output beat 0 from the just-updated
            // statistics so the first output appears on the next cycle.
            state_d     = S_EMIT;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;   // degree >= 2, so beat 0 is never last
            out_data_d  = emit_value((idx_d == '0) ? min2_d : min1_d,
                                     parity_d ^ sign_d[0]);
          end else begin
            cnt_d = next_k;
          end
        end
      end

      S_EMIT: begin
        if (out_fire) begin
          if (out_last_q) begin
            // Node done: reset statistics for the next node.
            state_d     = S_COLLECT;
            cnt_d       = '0;
            min1_d      = MAG_MAX;
            min2_d      = MAG_MAX;
            idx_d       = '0;
            parity_d    = 1'b0;
            sign_d      = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            cnt_d      = next_k;
            out_data_d = emit_value((idx_q == next_k) ? min2_q : min1_q,
                                    parity_q ^ sign_q[next_k]);
            out_last_d = (DW'(next_k) == DW'(deg_q - DW'(1)));
          end
        end
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase

    in_ready_d = (state_d == S_COLLECT);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_COLLECT;
      cnt_q       <= '0;
      deg_q       <= '0;
      min1_q      <= MAG_MAX;
      min2_q      <= MAG_MAX;
      idx_q       <= '0;
      parity_q    <= 1'b0;
      sign_q      <= '0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      deg_q       <= deg_d;
      min1_q      <= min1_d;
      min2_q      <= min2_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      sign_q      <= sign_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_out_last  = out_last_q;
  assign o_dbg_state = (state_q == S_EMIT);

endmodule
